// File: rtl/rotate_scheduler_pkg.sv
// Shared types and constants for the HEX character rotation scheduler.
package rotate_scheduler_pkg;

  localparam int SEL_W  = 2;
  localparam int CHAR_W = 2;
  localparam int NCHAR  = 4;
  localparam int DATA_W = CHAR_W * NCHAR;

  // Encoding 2'd3 is never entered and is treated as IDLE by the scheduler.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Rotation step: up or down, modulo 2**SEL_W.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur, input logic down);
    next_sel = down ? (cur - 1'b1) : (cur + 1'b1);
  endfunction

endpackage

// File: rtl/rotate_scheduler_tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while enabled, tc marks the last count.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/rotate_scheduler.sv
// Generates the rotation select and committed character word for the four HEX rotators.
// Handshake: none; start/stop/step are levels, load is a 1-cycle strobe; every output is registered.
module rotate_scheduler
  import rotate_scheduler_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic              step,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] chars,
  output logic              tick,
  output logic              wrap,
  output logic              busy,
  output logic [1:0]        state
);

  state_t            state_q;
  state_t            state_nxt;
  logic              step_q;
  logic [DATA_W-1:0] pending;
  logic              pend_vld;

  logic              in_run;
  logic              in_pause;
  logic              in_idle;
  logic              go_idle;
  logic              step_rise;
  logic              adv;
  logic              commit;
  logic              tc;
  logic [SEL_W-1:0]  sel_nxt;

  // Any state change restarts the prescaler so the first advance is always a full period away.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (in_run),
    .clr   (!in_run || (state_nxt != state_q)),
    .tc    (tc)
  );

  always_comb begin
    state_nxt = state_q;
    go_idle   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stop) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end else if (start) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        if (start && !stop) state_nxt = ST_RUN;
      end
    endcase
  end

  always_comb begin
    in_run    = (state_q == ST_RUN);
    in_pause  = (state_q == ST_PAUSE);
    in_idle   = !(in_run || in_pause);
    step_rise = step && !step_q;
    // A coincident start/stop transition takes priority over a step or terminal count.
    adv       = (in_run && tc && !stop) || (in_pause && step_rise && !start && !stop);
    sel_nxt   = next_sel(sel, dir);
    commit    = adv && (sel_nxt == '0) && pend_vld;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel      <= '0;
      chars    <= '0;
      pending  <= '0;
      pend_vld <= 1'b0;
      step_q   <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy    <= (state_nxt != ST_IDLE);
      step_q  <= step;
      tick    <= adv;
      wrap    <= adv && (sel_nxt == '0);

      if (go_idle)  sel <= '0;
      else if (adv) sel <= sel_nxt;

      if (load) pending <= data_in;

      if (in_idle) begin
        if (load) chars <= data_in;
        pend_vld <= 1'b0;
      end else if (go_idle) begin
        // Leaving for IDLE: flush the newest word so nothing is left stranded.
        if (load)          chars <= data_in;
        else if (pend_vld) chars <= pending;
        pend_vld <= 1'b0;
      end else begin
        if (commit) chars <= pending;
        if (load)        pend_vld <= 1'b1;
        else if (commit) pend_vld <= 1'b0;
      end
    end
  end

  assign state = state_q;

endmodule
